// File: rtl/time_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_pkg
//  Description : Shared definitions for the time-keeping controller: mode
//                encodings, the FSM state type and the BCD digit limits.
//  Revision    : 1.0  - initial release
// ============================================================================
package time_pkg;

    // Mode encodings as seen on the mode output
    localparam logic [1:0] c_MODE_RUN     = 2'd0;
    localparam logic [1:0] c_MODE_SET_HR  = 2'd1;
    localparam logic [1:0] c_MODE_SET_MIN = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN     = c_MODE_RUN,
        ST_SET_HR  = c_MODE_SET_HR,
        ST_SET_MIN = c_MODE_SET_MIN
    } state_t;

    // Digit limits
    localparam logic [3:0] c_MAX_ONES    = 4'd9;  // sec_o, min_o, hr_o
    localparam logic [3:0] c_MAX_TENS    = 4'd5;  // sec_t, min_t
    localparam logic [3:0] c_MAX_HR_T    = 4'd2;  // hr_t
    localparam logic [3:0] c_MAX_HR_O_TOP = 4'd3; // hr_o limit when hr_t == 2

endpackage : time_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD digit counter, 0..MAX, wrapping to 0.
//                Ports:
//                  clk, rst  - clock, asynchronous active-high reset
//                  clr_i     - synchronous clear (wins over inc_i)
//                  inc_i     - advance by one
//                  val_o     - current digit value
//                  co_o      - carry out, high when at MAX and inc_i
//  Revision    : 1.0  - initial release
// ============================================================================
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] val_o,
    output logic       co_o
);

    logic [3:0] val_q;
    logic [3:0] val_d;

    // >= rather than == so a corrupted value can never escape the range
    always_comb begin
        val_d = val_q;
        if (clr_i) begin
            val_d = 4'd0;
        end else if (inc_i) begin
            val_d = (val_q >= MAX) ? 4'd0 : val_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= 4'd0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;
    assign co_o  = (val_q == MAX) & inc_i;

endmodule : bcd_digit
`default_nettype wire

// File: rtl/time_keep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : time_keep_ctrl
//  Description : 24-hour HH:MM:SS clock with a RUN / SET_HR / SET_MIN mode
//                FSM. Six chained bcd_digit instances hold the time.
//                Ports:
//                  clk, rst          - clock, asynchronous active-high reset
//                  tick              - 1 Hz advance pulse (RUN only)
//                  mode_btn          - advance RUN -> SET_HR -> SET_MIN -> RUN
//                  inc_btn           - increment field being set
//                  sec_o..hr_t       - BCD digits of HH:MM:SS
//                  mode              - current mode encoding
//                  day_wrap          - one-cycle pulse on midnight rollover
//  Revision    : 1.0  - initial release
// ============================================================================
module time_keep_ctrl
    import time_pkg::*;
#(
    parameter int unsigned SET_CLEARS_SEC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] sec_o,
    output logic [3:0] sec_t,
    output logic [3:0] min_o,
    output logic [3:0] min_t,
    output logic [3:0] hr_o,
    output logic [3:0] hr_t,
    output logic [1:0] mode,
    output logic       day_wrap
);

    localparam logic c_SEC_CLR_EN = (SET_CLEARS_SEC != 0);

    state_t state_q;
    logic   day_wrap_q;

    logic w_run;
    logic w_set_hr;
    logic w_set_min;
    logic w_tick_run;
    logic w_inc_hr;
    logic w_inc_min;
    logic w_sec_clr;
    logic w_hr_adv;
    logic w_hr_23;
    logic w_hr_clr;
    logic w_day_roll;

    logic w_co_so;
    logic w_co_st;
    logic w_co_mo;
    logic w_co_mt;
    logic w_co_ho;
    logic w_co_ht;

    assign w_run     = (state_q == ST_RUN);
    assign w_set_hr  = (state_q == ST_SET_HR);
    assign w_set_min = (state_q == ST_SET_MIN);

    // tick acts alongside mode_btn in RUN; inc_btn loses to mode_btn
    assign w_tick_run = tick & w_run;
    assign w_inc_hr   = inc_btn & ~mode_btn & w_set_hr;
    assign w_inc_min  = inc_btn & ~mode_btn & w_set_min;
    assign w_sec_clr  = mode_btn & w_set_min & c_SEC_CLR_EN;

    // Minute carry only reaches the hours while running; in SET_MIN the
    // minute tens digit wraps on its own.
    assign w_hr_adv = (w_co_mt & w_tick_run) | w_inc_hr;
    assign w_hr_23  = (hr_t == c_MAX_HR_T) & (hr_o == c_MAX_HR_O_TOP);
    // A carry out of hr_t can only come from an illegal hour; clear it too.
    assign w_hr_clr = (w_hr_23 & w_hr_adv) | w_co_ht;

    assign w_day_roll = w_hr_23 & w_co_mt & w_tick_run;

    bcd_digit #(.MAX(c_MAX_ONES)) u_sec_o (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_sec_clr),
        .inc_i (w_tick_run),
        .val_o (sec_o),
        .co_o  (w_co_so)
    );

    bcd_digit #(.MAX(c_MAX_TENS)) u_sec_t (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_sec_clr),
        .inc_i (w_co_so),
        .val_o (sec_t),
        .co_o  (w_co_st)
    );

    bcd_digit #(.MAX(c_MAX_ONES)) u_min_o (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (w_co_st | w_inc_min),
        .val_o (min_o),
        .co_o  (w_co_mo)
    );

    bcd_digit #(.MAX(c_MAX_TENS)) u_min_t (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (w_co_mo),
        .val_o (min_t),
        .co_o  (w_co_mt)
    );

    bcd_digit #(.MAX(c_MAX_ONES)) u_hr_o (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_hr_clr),
        .inc_i (w_hr_adv),
        .val_o (hr_o),
        .co_o  (w_co_ho)
    );

    bcd_digit #(.MAX(c_MAX_HR_T)) u_hr_t (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_hr_clr),
        .inc_i (w_co_ho),
        .val_o (hr_t),
        .co_o  (w_co_ht)
    );

    // Mode FSM and registered rollover pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            day_wrap_q <= 1'b0;
        end else begin
            day_wrap_q <= w_day_roll;
            case (state_q)
                ST_RUN:     if (mode_btn) state_q <= ST_SET_HR;
                ST_SET_HR:  if (mode_btn) state_q <= ST_SET_MIN;
                ST_SET_MIN: if (mode_btn) state_q <= ST_RUN;
                default:    state_q <= ST_RUN;
            endcase
        end
    end

    assign mode     = state_q;
    assign day_wrap = day_wrap_q;

endmodule : time_keep_ctrl
`default_nettype wire
